// File: rtl/task_dispatcher_if.sv
// Queue-side and worker-side signals of the task dispatcher.
// Optional statistics signals exist only when TASK_DISPATCHER_STATS_EN is defined.
interface task_dispatcher_if #(
    parameter int NUM_WORKERS = 4
);
    logic [7:0]             q_task;
    logic                   q_empty;
    logic                   q_pop;
    logic [7:0]             worker_task;
    logic [NUM_WORKERS-1:0] worker_valid;
    logic [NUM_WORKERS-1:0] worker_ready;
    logic [NUM_WORKERS-1:0] worker_done;
    logic [NUM_WORKERS-1:0] busy;
    logic                   issuing;
`ifdef TASK_DISPATCHER_STATS_EN
    logic [15:0]            dispatch_count;
    logic [15:0]            stall_count;
`endif

    modport master (
        input  q_task, q_empty, worker_ready, worker_done,
        output q_pop, worker_task, worker_valid, busy, issuing
`ifdef TASK_DISPATCHER_STATS_EN
        , output dispatch_count, stall_count
`endif
    );

    modport slave (
        output q_task, q_empty, worker_ready, worker_done,
        input  q_pop, worker_task, worker_valid, busy, issuing
`ifdef TASK_DISPATCHER_STATS_EN
        , input dispatch_count, stall_count
`endif
    );
endinterface

// File: rtl/task_dispatcher.sv
// Pops tasks from the queue and issues them round-robin to free worker slots.
// Define TASK_DISPATCHER_STATS_EN to add saturating dispatch/stall counters.
module task_dispatcher #(
    parameter int NUM_WORKERS = 4,
    parameter int WID_WIDTH   = 2
) (
    input logic clk,
    input logic rst,
    task_dispatcher_if.master bus
);
    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [WID_WIDTH-1:0]   sel;
    logic [WID_WIDTH-1:0]   rr_ptr;
    logic [WID_WIDTH-1:0]   pick;
    logic [WID_WIDTH-1:0]   sel_inc;
    logic [7:0]             task_reg;
    logic [NUM_WORKERS-1:0] busy;
    logic [NUM_WORKERS-1:0] set_mask;
    logic                   all_busy;
    logic                   fetch;
    logic                   handshake;
    int                     idx;
    logic                   found;

    assign all_busy  = &busy;
    assign handshake = (state == ISSUE) && bus.worker_ready[sel];
    assign set_mask  = handshake ? (NUM_WORKERS'(1) << sel) : '0;
    assign sel_inc   = (int'(sel) == NUM_WORKERS - 1) ? '0 : sel + WID_WIDTH'(1);

    // First free worker at or above rr_ptr, wrapping around.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_WORKERS; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_WORKERS) idx = idx - NUM_WORKERS;
            if (!found && !busy[idx]) begin
                found = 1'b1;
                pick  = WID_WIDTH'(idx);
            end
        end
    end

    always_comb begin
        state_next = state;
        fetch      = 1'b0;
        case (state)
            IDLE: begin
                if (!rst && !bus.q_empty && !all_busy) begin
                    fetch      = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (handshake) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= '0;
            rr_ptr   <= '0;
            sel      <= '0;
            task_reg <= '0;
        end else begin
            state <= state_next;
            // A handshake target is never busy, so set and clear never collide.
            busy  <= (busy & ~bus.worker_done) | set_mask;
            if (fetch) begin
                task_reg <= bus.q_task;
                sel      <= pick;
            end
            if (handshake) rr_ptr <= sel_inc;
        end
    end

    assign bus.q_pop        = fetch;
    assign bus.worker_task  = task_reg;
    assign bus.worker_valid = (state == ISSUE) ? (NUM_WORKERS'(1) << sel) : '0;
    assign bus.busy         = busy;
    assign bus.issuing      = (state == ISSUE);

`ifdef TASK_DISPATCHER_STATS_EN
    logic [15:0] dispatch_count;
    logic [15:0] stall_count;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            dispatch_count <= '0;
            stall_count    <= '0;
        end else begin
            if (handshake) dispatch_count <= sat_inc(dispatch_count);
            if (!bus.q_empty && all_busy) stall_count <= sat_inc(stall_count);
        end
    end

    assign bus.dispatch_count = dispatch_count;
    assign bus.stall_count    = stall_count;
`endif
endmodule

// File: tb/tb_task_dispatcher.sv
// Cycle-by-cycle vector bench for task_dispatcher with four workers.
module tb_task_dispatcher;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    task_dispatcher_if #(.NUM_WORKERS(4)) bus ();

    task_dispatcher #(.NUM_WORKERS(4), .WID_WIDTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    typedef struct {
        logic       rst;
        logic       q_empty;
        logic [7:0] q_task;
        logic [3:0] ready;
        logic [3:0] done;
        logic       pop;
        logic [3:0] valid;
        logic       chk_task;
        logic [7:0] wtask;
        logic [3:0] busy;
        logic       iss;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input logic r, input logic e, input logic [7:0] t, input logic [3:0] rd,
                       input logic [3:0] dn, input logic p, input logic [3:0] v,
                       input logic ct, input logic [7:0] wt, input logic [3:0] b, input logic is);
        vec_t x;
        x = '{r, e, t, rd, dn, p, v, ct, wt, b, is};
        tbl.push_back(x);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        int pops;
        int waited;
        //   rst qe task   rdy      done     pop valid    ct  wtask  busy     iss
        add(1, 0, 8'hA1, 4'b1111, 4'b0000, 0, 4'b0000, 0, 8'h00, 4'b0000, 0); // 0 reset
        add(0, 0, 8'hA1, 4'b1111, 4'b0000, 1, 4'b0000, 0, 8'h00, 4'b0000, 0); // 1
        add(0, 0, 8'hB2, 4'b1111, 4'b0000, 0, 4'b0001, 1, 8'hA1, 4'b0000, 1); // 2
        add(0, 0, 8'hB2, 4'b1111, 4'b0000, 1, 4'b0000, 0, 8'h00, 4'b0001, 0); // 3
        add(0, 0, 8'hC3, 4'b1111, 4'b0000, 0, 4'b0010, 1, 8'hB2, 4'b0001, 1); // 4
        add(0, 0, 8'hC3, 4'b1111, 4'b0000, 1, 4'b0000, 0, 8'h00, 4'b0011, 0); // 5
        add(0, 0, 8'hD4, 4'b1111, 4'b0000, 0, 4'b0100, 1, 8'hC3, 4'b0011, 1); // 6
        add(0, 0, 8'hD4, 4'b1111, 4'b0000, 1, 4'b0000, 0, 8'h00, 4'b0111, 0); // 7
        add(0, 0, 8'h55, 4'b1111, 4'b0000, 0, 4'b1000, 1, 8'hD4, 4'b0111, 1); // 8
        add(0, 0, 8'h55, 4'b1111, 4'b0000, 0, 4'b0000, 0, 8'h00, 4'b1111, 0); // 9 stall
        add(0, 0, 8'h55, 4'b1111, 4'b0100, 0, 4'b0000, 0, 8'h00, 4'b1111, 0); // 10 stall, done[2]
        add(0, 0, 8'h55, 4'b1111, 4'b0000, 1, 4'b0000, 0, 8'h00, 4'b1011, 0); // 11
        add(0, 1, 8'h00, 4'b1111, 4'b0000, 0, 4'b0100, 1, 8'h55, 4'b1011, 1); // 12
        add(0, 1, 8'h00, 4'b1111, 4'b0010, 0, 4'b0000, 0, 8'h00, 4'b1111, 0); // 13 done[1]
        add(0, 0, 8'h9C, 4'b1101, 4'b0000, 1, 4'b0000, 0, 8'h00, 4'b1101, 0); // 14 sel 1
        for (int i = 0; i < 5; i++)
            add(0, 0, 8'h77, 4'b1101, 4'b0000, 0, 4'b0010, 1, 8'h9C, 4'b1101, 1); // 15..19 held
        add(0, 0, 8'h77, 4'b1111, 4'b0000, 0, 4'b0010, 1, 8'h9C, 4'b1101, 1); // 20 handshake
        add(0, 1, 8'h00, 4'b1111, 4'b1000, 0, 4'b0000, 0, 8'h00, 4'b1111, 0); // 21 done[3]
        add(0, 0, 8'h3B, 4'b1111, 4'b0000, 1, 4'b0000, 0, 8'h00, 4'b0111, 0); // 22 sel 3
        add(0, 1, 8'h00, 4'b1111, 4'b0001, 0, 4'b1000, 1, 8'h3B, 4'b0111, 1); // 23 done[0]+hs[3]
        add(0, 1, 8'h00, 4'b1111, 4'b0100, 0, 4'b0000, 0, 8'h00, 4'b1110, 0); // 24 done[2]
        add(0, 0, 8'h7E, 4'b1111, 4'b0000, 1, 4'b0000, 0, 8'h00, 4'b1010, 0); // 25 sel 0 (rr wrapped)
        add(1, 0, 8'h7E, 4'b0000, 4'b0000, 0, 4'b0001, 1, 8'h7E, 4'b1010, 1); // 26 reset in ISSUE
        add(1, 0, 8'h81, 4'b1111, 4'b0000, 0, 4'b0000, 0, 8'h00, 4'b0000, 0); // 27
        add(0, 0, 8'h81, 4'b1111, 4'b0000, 1, 4'b0000, 0, 8'h00, 4'b0000, 0); // 28
        add(0, 1, 8'h00, 4'b1111, 4'b0000, 0, 4'b0001, 1, 8'h81, 4'b0000, 1); // 29
        add(0, 1, 8'h00, 4'b1111, 4'b0010, 0, 4'b0000, 0, 8'h00, 4'b0001, 0); // 30 done on idle worker
        add(0, 0, 8'h92, 4'b1111, 4'b0000, 1, 4'b0000, 0, 8'h00, 4'b0001, 0); // 31 sel 1
        add(0, 1, 8'h00, 4'b1111, 4'b0000, 0, 4'b0010, 1, 8'h92, 4'b0001, 1); // 32
        add(0, 1, 8'h00, 4'b1111, 4'b0000, 0, 4'b0000, 0, 8'h00, 4'b0011, 0); // 33

        bus.q_empty      = 1'b1;
        bus.q_task       = 8'h00;
        bus.worker_ready = 4'b0000;
        bus.worker_done  = 4'b0000;
        rst              = 1'b1;
        repeat (2) @(posedge clk);

        for (int r = 0; r < tbl.size(); r++) begin
            @(posedge clk);
            #1;
            rst              = tbl[r].rst;
            bus.q_empty      = tbl[r].q_empty;
            bus.q_task       = tbl[r].q_task;
            bus.worker_ready = tbl[r].ready;
            bus.worker_done  = tbl[r].done;
            @(negedge clk);
            check($sformatf("q_pop[%0d]", r),        int'(bus.q_pop),        int'(tbl[r].pop));
            check($sformatf("worker_valid[%0d]", r), int'(bus.worker_valid), int'(tbl[r].valid));
            check($sformatf("busy[%0d]", r),         int'(bus.busy),         int'(tbl[r].busy));
            check($sformatf("issuing[%0d]", r),      int'(bus.issuing),      int'(tbl[r].iss));
            if (tbl[r].chk_task)
                check($sformatf("worker_task[%0d]", r), int'(bus.worker_task), int'(tbl[r].wtask));
`ifdef TASK_DISPATCHER_STATS_EN
            if (r == 12) begin
                check("stall_count", int'(bus.stall_count), 2);
                check("dispatch_count", int'(bus.dispatch_count), 4);
            end
            if (r == 27) begin
                check("stall_count_rst", int'(bus.stall_count), 0);
                check("dispatch_count_rst", int'(bus.dispatch_count), 0);
            end
`endif
        end

        // Hand-driven: worker 2 selected, ready withheld, bounded waits throughout.
        @(posedge clk);
        #1;
        bus.q_empty      = 1'b0;
        bus.q_task       = 8'h5A;
        bus.worker_ready = 4'b0000;
        bus.worker_done  = 4'b0000;
        pops   = 0;
        waited = 0;
        @(negedge clk);
        while (!bus.q_pop && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        check("pop_wait", int'(bus.q_pop), 1);
        pops++;
        @(posedge clk);
        #1;
        bus.q_empty = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (bus.q_pop) pops++;
            check($sformatf("hold_valid[%0d]", c), int'(bus.worker_valid), 4'b0100);
            check($sformatf("hold_task[%0d]", c),  int'(bus.worker_task),  8'h5A);
            @(posedge clk);
            #1;
        end
        bus.worker_ready = 4'b0100;
        @(negedge clk);
        check("hs_valid", int'(bus.worker_valid), 4'b0100);
        @(posedge clk);
        #1;
        bus.worker_ready = 4'b0000;
        @(negedge clk);
        check("hs_busy", int'(bus.busy), 4'b0111);
        check("hs_idle", int'(bus.issuing), 0);
        check("pop_total", pops, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
